// File: rtl/axi_bridge_nport.sv
// axi_bridge_nport: round-robin bridge from NPORT SRAM-style requesters onto one AXI3 master
module axi_bridge_nport #(
  parameter int NPORT     = 2,
  parameter int BURST_LEN = 8
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [NPORT-1:0]     port_req,
  input  logic [4*NPORT-1:0]   port_wen,
  input  logic [NPORT-1:0]     port_burst,
  input  logic [32*NPORT-1:0]  port_addr,
  input  logic [32*NPORT-1:0]  port_wdata,
  output logic [NPORT-1:0]     port_gnt,
  output logic [NPORT-1:0]     port_rvalid,
  output logic                 port_rlast,
  output logic [31:0]          port_rdata,
  output logic [NPORT-1:0]     port_done,
  output logic [NPORT-1:0]     port_err,
  output logic [3:0]           arid,
  output logic [31:0]          araddr,
  output logic [3:0]           arlen,
  output logic [2:0]           arsize,
  output logic [1:0]           arburst,
  output logic [1:0]           arlock,
  output logic [3:0]           arcache,
  output logic [2:0]           arprot,
  output logic                 arvalid,
  input  logic                 arready,
  input  logic [3:0]           rid,
  input  logic [31:0]          rdata,
  input  logic [1:0]           rresp,
  input  logic                 rlast,
  input  logic                 rvalid,
  output logic                 rready,
  output logic [3:0]           awid,
  output logic [31:0]          awaddr,
  output logic [3:0]           awlen,
  output logic [2:0]           awsize,
  output logic [1:0]           awburst,
  output logic [1:0]           awlock,
  output logic [3:0]           awcache,
  output logic [2:0]           awprot,
  output logic                 awvalid,
  input  logic                 awready,
  output logic [3:0]           wid,
  output logic [31:0]          wdata,
  output logic [3:0]           wstrb,
  output logic                 wlast,
  output logic                 wvalid,
  input  logic                 wready,
  input  logic [3:0]           bid,
  input  logic [1:0]           bresp,
  input  logic                 bvalid,
  output logic                 bready
);
  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WRESP} state_t;
  state_t state, state_nx;
  logic [3:0] ptr, owner, sel, s_wen, wen_q;
  logic [4:0] idx;
  logic [31:0] req_ext, s_addr, s_wdata, addr_q, wdata_q;
  logic s_burst, burst_q, found, err_q, aw_done, w_done;
  logic [NPORT-1:0] sel_oh, own_oh;
  assign sel_oh = NPORT'(1) << sel;
  assign own_oh = NPORT'(1) << owner;
  // round-robin search upward from the port after the last owner
  always_comb begin
    req_ext = 32'(port_req);
    found = 1'b0;
    sel = '0;
    idx = '0;
    for (int i = 1; i <= NPORT; i++) begin
      idx = {1'b0, ptr} + 5'(i);
      if (idx >= 5'(NPORT)) idx = idx - 5'(NPORT);
      if (!found && req_ext[idx]) begin
        found = 1'b1;
        sel = idx[3:0];
      end
    end
  end
  // mux out the selected requester's command fields
  always_comb begin
    s_addr = '0;
    s_wdata = '0;
    s_wen = '0;
    s_burst = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      if (4'(i) == sel) begin
        s_addr = port_addr[i*32 +: 32];
        s_wdata = port_wdata[i*32 +: 32];
        s_wen = port_wen[i*4 +: 4];
        s_burst = port_burst[i];
      end
    end
  end
  // state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else state <= state_nx;
  end
  // next state and handshake outputs
  always_comb begin
    state_nx = state;
    arvalid = 1'b0;
    rready = 1'b0;
    awvalid = 1'b0;
    wvalid = 1'b0;
    bready = 1'b0;
    port_rvalid = '0;
    port_done = '0;
    port_err = '0;
    case (state)
      IDLE: if (found) state_nx = (s_wen == 4'd0) ? RADDR : WADDR;
      RADDR: begin
        arvalid = 1'b1;
        if (arready) state_nx = RDATA;
      end
      RDATA: begin
        rready = 1'b1;
        port_rvalid = rvalid ? own_oh : '0;
        if (rvalid && rlast) begin
          state_nx = IDLE;
          port_done = own_oh;
          port_err = (err_q || rresp != 2'b00) ? own_oh : '0;
        end
      end
      WADDR: begin
        awvalid = !aw_done;
        wvalid = !w_done;
        if ((aw_done || awready) && (w_done || wready)) state_nx = WRESP;
      end
      WRESP: begin
        bready = 1'b1;
        if (bvalid) begin
          state_nx = IDLE;
          port_done = own_oh;
          port_err = (bresp != 2'b00) ? own_oh : '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  // latch the granted command, grant pulse, sticky read error and write handshake flags
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ptr <= 4'(NPORT - 1);
      owner <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      wen_q <= '0;
      burst_q <= 1'b0;
      port_gnt <= '0;
      err_q <= 1'b0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
    end else begin
      port_gnt <= (state == IDLE && found) ? sel_oh : '0;
      if (state == IDLE && found) begin
        owner <= sel;
        ptr <= sel;
        addr_q <= s_addr;
        wdata_q <= s_wdata;
        wen_q <= s_wen;
        burst_q <= s_burst;
      end
      err_q <= (state == RDATA && rvalid) ? (!rlast && (err_q || rresp != 2'b00)) : err_q;
      aw_done <= (state == WADDR && state_nx == WADDR) && (aw_done || awready);
      w_done <= (state == WADDR && state_nx == WADDR) && (w_done || wready);
    end
  end
  assign arid = owner;
  assign araddr = burst_q ? (addr_q & ~32'(BURST_LEN*4 - 1)) : addr_q;
  assign arlen = burst_q ? 4'(BURST_LEN - 1) : 4'd0;
  assign arsize = 3'd2;
  assign arburst = 2'b01;
  assign arlock = 2'b00;
  assign arcache = 4'd0;
  assign arprot = 3'd0;
  assign awid = owner;
  assign awaddr = addr_q;
  assign awlen = 4'd0;
  assign awsize = 3'd2;
  assign awburst = 2'b01;
  assign awlock = 2'b00;
  assign awcache = 4'd0;
  assign awprot = 3'd0;
  assign wid = owner;
  assign wdata = wdata_q;
  assign wstrb = wen_q;
  assign wlast = 1'b1;
  assign port_rdata = (state == RDATA) ? rdata : '0;
  assign port_rlast = (state == RDATA) && rlast;
endmodule

// File: tb/tb_axi_bridge_nport.sv
// tb_axi_bridge_nport: directed bench with an AXI slave model and a read-beat scoreboard
module tb_axi_bridge_nport;
  localparam int NP = 3;
  localparam int BL = 8;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [NP-1:0] port_req, port_burst, port_gnt, port_rvalid, port_done, port_err;
  logic [4*NP-1:0] port_wen;
  logic [32*NP-1:0] port_addr, port_wdata;
  logic port_rlast;
  logic [31:0] port_rdata;
  logic [3:0] arid, arlen, arcache, awid, awlen, awcache, wid, wstrb, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [2:0] arsize, arprot, awsize, awprot;
  logic [1:0] arburst, arlock, awburst, awlock, rresp, bresp;
  logic arvalid, arready, rlast, rvalid, rready, awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  int pass_cnt = 0;
  int total = 0;
  logic [32:0] sb[$];
  int g, n;
  always #5 aclk = ~aclk;
  axi_bridge_nport #(.NPORT(NP), .BURST_LEN(BL)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .port_req(port_req), .port_wen(port_wen), .port_burst(port_burst),
    .port_addr(port_addr), .port_wdata(port_wdata),
    .port_gnt(port_gnt), .port_rvalid(port_rvalid), .port_rlast(port_rlast),
    .port_rdata(port_rdata), .port_done(port_done), .port_err(port_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic set_port(input int p, input logic [3:0] wen, input logic burst, input logic [31:0] a, input logic [31:0] d);
    port_wen[p*4 +: 4] = wen;
    port_burst[p] = burst;
    port_addr[p*32 +: 32] = a;
    port_wdata[p*32 +: 32] = d;
  endtask
  task automatic wait_gnt(output int gp, output int cyc);
    gp = -1;
    cyc = 0;
    while (gp < 0 && cyc < 20) begin
      @(negedge aclk);
      #1;
      for (int i = 0; i < NP; i++) if (port_gnt[i]) gp = i;
      if (gp < 0) cyc++;
    end
    chk("gnt_seen", 32'(gp >= 0), 1);
    if (gp >= 0) begin
      @(negedge aclk);
      port_req[gp] = 1'b0;
      #1;
      chk("gnt_pulse", 32'(port_gnt), 0);
    end
  endtask
  task automatic serve_read(input int id, input logic [31:0] ea, input logic [3:0] el, input int nb,
                            input int eb, input bit gaps, input logic [31:0] base);
    int w = 0;
    logic [32:0] e;
    logic [NP-1:0] oh;
    oh = NP'(1) << id;
    #1;
    while (!arvalid && w < 20) begin
      @(negedge aclk);
      #1;
      w++;
    end
    chk("arvalid", 32'(arvalid), 1);
    chk("araddr", araddr, ea);
    chk("arlen", 32'(arlen), 32'(el));
    chk("arid", 32'(arid), 32'(id));
    chk("arsize", 32'(arsize), 2);
    chk("arburst", 32'(arburst), 1);
    arready = 1'b1;
    @(negedge aclk);
    arready = 1'b0;
    #1;
    chk("rready", 32'(rready), 1);
    for (int b = 0; b < nb; b++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        rvalid = 1'b0;
        #1;
        chk("rvalid_gap", 32'(port_rvalid), 0);
        @(negedge aclk);
      end
      rvalid = 1'b1;
      rdata = base + 32'(b);
      rlast = (b == nb - 1);
      rresp = (b == eb) ? 2'b10 : 2'b00;
      sb.push_back({rlast, rdata});
      #1;
      chk("port_rvalid", 32'(port_rvalid), 32'(oh));
      if (port_rvalid != 0 && sb.size() > 0) begin
        e = sb.pop_front();
        chk("port_rdata", port_rdata, e[31:0]);
        chk("port_rlast", 32'(port_rlast), 32'(e[32]));
      end
      chk("rd_done", 32'(port_done), (b == nb - 1) ? 32'(oh) : 0);
      chk("rd_err", 32'(port_err), (b == nb - 1 && eb >= 0) ? 32'(oh) : 0);
      @(negedge aclk);
    end
    rvalid = 1'b0;
    rlast = 1'b0;
    rresp = 2'b00;
    #1;
    chk("rd_done_clear", 32'(port_done), 0);
  endtask
  task automatic serve_write(input int id, input logic [31:0] ea, input logic [3:0] es, input logic [31:0] ed, input logic [1:0] br);
    int w = 0;
    logic [NP-1:0] oh;
    oh = NP'(1) << id;
    #1;
    while (!awvalid && w < 20) begin
      @(negedge aclk);
      #1;
      w++;
    end
    chk("awvalid", 32'(awvalid), 1);
    chk("wvalid", 32'(wvalid), 1);
    chk("awaddr", awaddr, ea);
    chk("awlen", 32'(awlen), 0);
    chk("awid", 32'(awid), 32'(id));
    chk("wid", 32'(wid), 32'(id));
    chk("wdata", wdata, ed);
    chk("wstrb", 32'(wstrb), 32'(es));
    chk("wlast", 32'(wlast), 1);
    wready = 1'b1;
    @(negedge aclk);
    wready = 1'b0;
    #1;
    chk("w_drop", 32'(wvalid), 0);
    chk("aw_hold1", 32'(awvalid), 1);
    @(negedge aclk);
    #1;
    chk("aw_hold2", 32'(awvalid), 1);
    @(negedge aclk);
    awready = 1'b1;
    #1;
    chk("aw_hold3", 32'(awvalid), 1);
    @(negedge aclk);
    awready = 1'b0;
    #1;
    chk("aw_drop", 32'(awvalid), 0);
    chk("bready", 32'(bready), 1);
    chk("wr_no_done", 32'(port_done), 0);
    bvalid = 1'b1;
    bresp = br;
    #1;
    chk("wr_done", 32'(port_done), 32'(oh));
    chk("wr_err", 32'(port_err), (br != 2'b00) ? 32'(oh) : 0);
    @(negedge aclk);
    bvalid = 1'b0;
    bresp = 2'b00;
    #1;
    chk("wr_done_clear", 32'(port_done), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    int exp2[4] = '{0, 1, 0, 1};
    int exp3[4] = '{0, 1, 2, 0};
    port_req = '0;
    port_wen = '0;
    port_burst = '0;
    port_addr = '0;
    port_wdata = '0;
    {arready, rvalid, rlast, awready, wready, bvalid} = '0;
    rid = '0;
    bid = '0;
    rdata = '0;
    rresp = '0;
    bresp = '0;
    @(negedge aclk);
    #1;
    chk("rst_arvalid", 32'(arvalid), 0);
    chk("rst_awvalid", 32'(awvalid), 0);
    chk("rst_wvalid", 32'(wvalid), 0);
    chk("rst_rready", 32'(rready), 0);
    chk("rst_bready", 32'(bready), 0);
    chk("rst_gnt", 32'(port_gnt), 0);
    chk("rst_done", 32'(port_done), 0);
    chk("rst_err", 32'(port_err), 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_wstrb", 32'(wstrb), 0);
    aresetn = 1'b1;
    @(negedge aclk);
    set_port(0, 4'd0, 1'b0, 32'h1FC0_0004, 32'd0);
    port_req[0] = 1'b1;
    wait_gnt(g, n);
    chk("single_gnt", 32'(g), 0);
    chk("single_gnt_latency", 32'(n), 0);
    serve_read(0, 32'h1FC0_0004, 4'd0, 1, -1, 1'b0, 32'hDEAD_BEEF);
    set_port(1, 4'd0, 1'b1, 32'h0000_1234, 32'd0);
    port_req[1] = 1'b1;
    wait_gnt(g, n);
    chk("burst_gnt", 32'(g), 1);
    serve_read(1, 32'h0000_1220, 4'd7, BL, -1, 1'b1, 32'd0);
    set_port(0, 4'b0011, 1'b0, 32'h0000_2000, 32'h1234_5678);
    port_req[0] = 1'b1;
    wait_gnt(g, n);
    chk("write_gnt", 32'(g), 0);
    serve_write(0, 32'h0000_2000, 4'b0011, 32'h1234_5678, 2'b10);
    set_port(2, 4'd0, 1'b1, 32'h0000_4008, 32'd0);
    port_req[2] = 1'b1;
    wait_gnt(g, n);
    chk("err_burst_gnt", 32'(g), 2);
    serve_read(2, 32'h0000_4000, 4'd7, BL, 3, 1'b1, 32'h100);
    set_port(0, 4'd0, 1'b0, 32'h10, 32'd0);
    set_port(1, 4'd0, 1'b0, 32'h20, 32'd0);
    port_req[1:0] = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(g, n);
      chk("rr2_order", 32'(g), 32'(exp2[k]));
      if (g < 0) break;
      serve_read(g, (g == 1) ? 32'h20 : 32'h10, 4'd0, 1, -1, 1'b0, 32'hA000_0000 + 32'(k));
      if (k < 2) port_req[g] = 1'b1;
    end
    set_port(1, 4'd0, 1'b1, 32'h40, 32'd0);
    port_req[1] = 1'b1;
    wait_gnt(g, n);
    chk("rst_mid_gnt", 32'(g), 1);
    #1;
    chk("rst_mid_arvalid", 32'(arvalid), 1);
    arready = 1'b1;
    @(negedge aclk);
    arready = 1'b0;
    rvalid = 1'b1;
    rdata = 32'h5555_0001;
    #1;
    chk("rst_mid_rvalid", 32'(port_rvalid), 2);
    aresetn = 1'b0;
    #1;
    chk("rst_mid_arvalid0", 32'(arvalid), 0);
    chk("rst_mid_rready0", 32'(rready), 0);
    chk("rst_mid_prvalid0", 32'(port_rvalid), 0);
    chk("rst_mid_done0", 32'(port_done), 0);
    chk("rst_mid_araddr0", araddr, 0);
    rvalid = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    for (int p = 0; p < NP; p++) set_port(p, 4'd0, 1'b0, 32'(256 * (p + 1)), 32'd0);
    port_req = '1;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(g, n);
      chk("rr3_order", 32'(g), 32'(exp3[k]));
      if (k == 0) chk("rr3_fresh_latency", 32'(n), 0);
      if (g < 0) break;
      serve_read(g, 32'(256 * (g + 1)), 4'd0, 1, -1, 1'b0, 32'hB000_0000 + 32'(k));
      if (k == 0) port_req[g] = 1'b1;
    end
    chk("sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
